// File: rtl/seq_div_16by8_pkg.sv
// Shared widths, FSM encoding and result constants for the sequential 16/8 divider.
package seq_div_16by8_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;
    localparam int CW_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // A zero divisor reports an all-ones quotient of whatever width the divider has.
    localparam logic DBZ_FILL = 1'b1;
    localparam logic [DW_DEF-1:0] DBZ_QUOT = {DW_DEF{DBZ_FILL}};

endpackage

// File: rtl/seq_div_16by8_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract D,
// restore on borrow.
module seq_div_16by8_div_step
    import seq_div_16by8_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   r_i,
    input  logic          bit_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   r_o,
    output logic          q_o
);

    logic [VW:0] t_w;
    logic [VW:0] diff_w;
    logic        borrow_w;
    logic        unused_r_msb;

    // R stays below D, so its top bit is always clear and only the low bits shift up.
    assign unused_r_msb = r_i[VW];

    assign t_w = {r_i[VW-1:0], bit_i};
    assign {borrow_w, diff_w} = {1'b0, t_w} - {2'b00, d_i};

    assign r_o = borrow_w ? t_w : diff_w;
    assign q_o = ~borrow_w;

endmodule

// File: rtl/seq_div_16by8.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_div_16by8
    import seq_div_16by8_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
    localparam logic [DW-1:0] QUOT_DBZ  = {DW{DBZ_FILL}};

    state_e        state_q;
    logic [DW-1:0] q_q;
    logic [VW-1:0] d_q;
    logic [VW:0]   r_q;
    logic [CW-1:0] cnt_q;
    logic          dbz_pend_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quot_q;
    logic [VW-1:0] rem_q;
    logic          dbz_q;

    logic [VW:0]   r_d;
    logic          q_bit_d;

    seq_div_16by8_div_step #(
        .VW (VW)
    ) u_step (
        .r_i   (r_q),
        .bit_i (q_q[DW-1]),
        .d_i   (d_q),
        .r_o   (r_d),
        .q_o   (q_bit_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            d_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        q_q        <= dividend;
                        d_q        <= divisor;
                        r_q        <= '0;
                        busy_q     <= 1'b1;
                        dbz_pend_q <= (divisor == '0);
                        state_q    <= ST_RUN;
                        // Zero divisor: preload the last count so a single frozen
                        // RUN cycle leads straight to FIN, giving a 2-cycle result.
                        cnt_q      <= (divisor == '0) ? LAST_ITER : '0;
                    end
                end
                ST_RUN: begin
                    if (!dbz_pend_q) begin
                        r_q <= r_d;
                        q_q <= {q_q[DW-2:0], q_bit_d};
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dbz_q   <= dbz_pend_q;
                    state_q <= ST_IDLE;
                    if (dbz_pend_q) begin
                        quot_q <= QUOT_DBZ;
                        rem_q  <= q_q[VW-1:0];
                    end else begin
                        quot_q <= q_q;
                        rem_q  <= r_q[VW-1:0];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench: directed cases with literal results plus random operands
// checked every cycle against an arithmetic latency/result model.
`timescale 1ns/1ps
module tb_seq_div_16by8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    seq_div_16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: fixed latency per operation, results from plain / and %.
    logic        m_busy, m_done, m_dbz, p_dbz;
    logic [15:0] m_q, p_q, m_a, p_a;
    logic [7:0]  m_r, p_r, m_b, p_b;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_q = 0; m_r = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_a = p_a; m_b = p_b;
                end
            end else if (start) begin
                m_busy = 1;
                p_a = dividend;
                p_b = divisor;
                if (divisor == 8'd0) begin
                    m_left = 2; p_q = 16'hFFFF; p_r = dividend[7:0]; p_dbz = 1;
                end else begin
                    m_left = 17;
                    p_q = dividend / {8'd0, divisor};
                    p_r = 8'(dividend % {8'd0, divisor});
                    p_dbz = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("quotient", 32'(quotient), 32'(m_q));
            chk("remainder", 32'(remainder), 32'(m_r));
            chk("dbz", 32'(dbz), 32'(m_dbz));
            if (m_done && !m_dbz) begin
                chk("q*d+r", 32'(quotient) * 32'(m_b) + 32'(remainder), 32'(m_a));
                chk("r<d", 32'(remainder < m_b), 32'd1);
            end
        end
    end

    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 16'($urandom); divisor = 8'($urandom);
    endtask

    task automatic wait_done(input int lat, input int exp_busy, input string nm);
        int n;
        int bc;
        n = 0;
        bc = int'(busy);
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            bc += int'(busy);
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        if (exp_busy >= 0) chk({nm, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    endtask

    task automatic chk_res(input logic [15:0] q, input logic [7:0] r, input logic z, input string nm);
        chk({nm, "_q"}, 32'(quotient), 32'(q));
        chk({nm, "_r"}, 32'(remainder), 32'(r));
        chk({nm, "_dbz"}, 32'(dbz), 32'(z));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        logic [15:0] a;
        logic [7:0]  b;
        rst = 0; start = 0; dividend = 0; divisor = 0;
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        chk_res(16'd0, 8'd0, 1'b0, "reset");
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        start_op(16'd100, 8'd7);
        wait_done(17, 17, "100_7");
        chk_res(16'd14, 8'd2, 1'b0, "100_7");

        start_op(16'd65535, 8'd255);
        wait_done(17, 17, "65535_255");
        chk_res(16'd257, 8'd0, 1'b0, "65535_255");
        start_op(16'd65535, 8'd1);
        wait_done(17, 17, "65535_1");
        chk_res(16'd65535, 8'd0, 1'b0, "65535_1");

        start_op(16'd5, 8'd9);
        wait_done(17, 17, "5_9");
        chk_res(16'd0, 8'd5, 1'b0, "5_9");
        start_op(16'd0, 8'd3);
        wait_done(17, 17, "0_3");
        chk_res(16'd0, 8'd0, 1'b0, "0_3");

        start_op(16'h1234, 8'd0);
        wait_done(2, 2, "dbz");
        chk_res(16'hFFFF, 8'h34, 1'b1, "dbz");
        start_op(16'd50, 8'd5);
        wait_done(17, 17, "50_5");
        chk_res(16'd10, 8'd0, 1'b0, "50_5");

        start_op(16'd1000, 8'd3);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; dividend = 16'd9; divisor = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(12, -1, "ignored_start");
        chk_res(16'd333, 8'd1, 1'b0, "1000_3");
        start_op(16'd9, 8'd9);
        wait_done(17, 17, "b2b_9_9");
        chk_res(16'd1, 8'd0, 1'b0, "b2b_9_9");

        start_op(16'd40000, 8'd200);
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk_res(16'd0, 8'd0, 1'b0, "midop_rst");
        chk("midop_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_cnt = 0;
        repeat (25) begin
            @(posedge clk); #1;
            done_cnt += int'(done);
        end
        chk("midop_rst_no_done", 32'(done_cnt), 32'd0);
        chk("midop_rst_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 2500; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            start_op(a, b);
            if (b != 8'd0 && $urandom_range(0, 3) == 0) begin
                repeat (2) begin @(posedge clk); #1; end
                start = 1'b1; dividend = 16'($urandom); divisor = 8'($urandom);
                @(posedge clk); #1;
                start = 1'b0;
                wait_done(14, -1, "rand_junk");
            end else begin
                wait_done((b == 8'd0) ? 2 : 17, -1, "rand");
            end
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
